// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding, default operand width and the iteration-counter width.
package mult_pkg;

  // Operand width used when no override is given.
  localparam int DEFAULT_WIDTH = 4;

  // Control FSM states; code 2'd3 is illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed for an iteration counter that must reach 'width'.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_shift_add_if.sv
// Start/done handshake plus operand and product buses of the multiplier.
// The ALU/control side uses the master modport, the multiplier the slave one.
interface mult_shift_add_if
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic               St;
  logic [WIDTH-1:0]   Mplier;
  logic [WIDTH-1:0]   Mcand;
  logic               Busy;
  logic               Done;
  logic [2*WIDTH-1:0] Product;

  modport master (output St, output Mplier, output Mcand,
                  input Busy, input Done, input Product);

  modport slave  (input St, input Mplier, input Mcand,
                  output Busy, output Done, output Product);
endinterface

// File: rtl/acc_param.sv
// Parametrised (2*WIDTH+1)-bit accumulator register.
// Load copies Entradas in; Ad adds Entradas[WIDTH-1:0] to the upper WIDTH+1
// bits when the accumulator LSB (current multiplier bit) is set; Sh shifts the
// whole word right by one. Ad and Sh together perform add-then-shift in one edge.
module acc_param
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Load,
  input  logic               Ad,
  input  logic               Sh,
  input  logic [2*WIDTH:0]   Entradas,
  output logic [2*WIDTH:0]   Saidas
);

  logic [2*WIDTH:0] acc_q, acc_d;
  logic [WIDTH:0]   upper_sum;

  // Next accumulator value: load has priority over add/shift.
  always_comb begin
    acc_d     = acc_q;
    upper_sum = acc_q[2*WIDTH:WIDTH]
              + {1'b0, ((Ad && acc_q[0]) ? Entradas[WIDTH-1:0] : {WIDTH{1'b0}})};
    if (Load) begin
      acc_d = Entradas;
    end else if (Sh) begin
      acc_d = {1'b0, upper_sum, acc_q[WIDTH-1:1]};
    end else if (Ad) begin
      acc_d = {upper_sum, acc_q[WIDTH-1:0]};
    end
  end

  // Accumulator register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign Saidas = acc_q;

endmodule

// File: rtl/mult_shift_add.sv
// Sequential shift-and-add multiplier: one add-and-shift per cycle, WIDTH
// iterations, then a one-cycle Done pulse with the registered Product.
// Optional macro MULT_SIGNED_EN: operands are two's complement; magnitudes are
// multiplied and the product is negated on completion when the signs differ.
module mult_shift_add
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic            Clk,
  input  logic            Reset,
  mult_shift_add_if.slave bus
);

  localparam int CW = count_width(WIDTH);

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [2*WIDTH:0]   acc_in, acc_out;
  logic               acc_load, acc_ad, acc_sh;

  logic [WIDTH-1:0]   mplier_mag, mcand_mag;
  logic [WIDTH:0]     run_sum;
  logic [2*WIDTH-1:0] product_raw;

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;

  // Magnitudes of the signed operands; -2^(W-1) maps to 2^(W-1) unsigned.
  always_comb begin
    mplier_mag = bus.Mplier[WIDTH-1] ? -bus.Mplier : bus.Mplier;
    mcand_mag  = bus.Mcand[WIDTH-1]  ? -bus.Mcand  : bus.Mcand;
  end
`else
  assign mplier_mag = bus.Mplier;
  assign mcand_mag  = bus.Mcand;
`endif

  acc_param #(.WIDTH(WIDTH)) u_acc (
    .Clk      (Clk),
    .Reset    (Reset),
    .Load     (acc_load),
    .Ad       (acc_ad),
    .Sh       (acc_sh),
    .Entradas (acc_in),
    .Saidas   (acc_out)
  );

  // Result of the current iteration (accumulator after add-and-shift),
  // needed so Product can be latched on the same edge as the last shift.
  always_comb begin
    run_sum     = acc_out[2*WIDTH:WIDTH]
                + {1'b0, (acc_out[0] ? mcand_q : {WIDTH{1'b0}})};
    product_raw = {run_sum, acc_out[WIDTH-1:1]};
  end

  // Next-state and datapath control for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    product_d = product_q;
    acc_load  = 1'b0;
    acc_ad    = 1'b0;
    acc_sh    = 1'b0;
    acc_in    = {{(WIDTH+1){1'b0}}, mcand_q};
`ifdef MULT_SIGNED_EN
    neg_d     = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.St) begin
          acc_load = 1'b1;
          acc_in   = {{(WIDTH+1){1'b0}}, mplier_mag};
          mcand_d  = mcand_mag;
          count_d  = '0;
`ifdef MULT_SIGNED_EN
          neg_d    = bus.Mplier[WIDTH-1] ^ bus.Mcand[WIDTH-1];
`endif
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_ad  = 1'b1;
        acc_sh  = 1'b1;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH-1)) begin
`ifdef MULT_SIGNED_EN
          product_d = neg_q ? -product_raw : product_raw;
`else
          product_d = product_raw;
`endif
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and result registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      mcand_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
    end
  end

`ifdef MULT_SIGNED_EN
  // Sign of the pending product, captured at load.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end
`endif

  assign bus.Busy    = (state_q == RUN);
  assign bus.Done    = (state_q == DONE);
  assign bus.Product = product_q;

endmodule

// File: tb/tb_mult_shift_add.sv
// Self-checking bench for mult_shift_add: a cycle-level behavioural model
// (phase counter plus arithmetic product) checked every cycle, directed
// operations with literal expectations, and a randomized stimulus phase.
module tb_mult_shift_add;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_shift_add_if #(.WIDTH(W)) bus ();

  mult_shift_add #(.WIDTH(W)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: phase 0 = idle, 1..W = computing, W+1 = done cycle.
  int               phase     = 0;
  logic [2*W-1:0]   m_prod    = '0;
  logic [2*W-1:0]   m_pending = '0;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_SIGNED_EN
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return (2*W)'(sa * sb);
`else
    return (2*W)'(int'(a) * int'(b));
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance the model on every rising edge, then compare shortly after.
  always @(posedge clk) begin
    if (rst) begin
      phase  = 0;
      m_prod = '0;
    end else if (phase == 0) begin
      if (bus.St === 1'b1) begin
        phase     = 1;
        m_pending = ref_mul(bus.Mplier, bus.Mcand);
      end
    end else if (phase < W + 1) begin
      phase++;
      if (phase == W + 1) m_prod = m_pending;
    end else begin
      phase = 0;
    end
    #1;
    chk("busy",    64'(bus.Busy),    64'(phase >= 1 && phase <= W));
    chk("done",    64'(bus.Done),    64'(phase == W + 1));
    chk("product", 64'(bus.Product), 64'(m_prod));
  end

  // One operation: pulse St, optionally change operands mid-run, wait for Done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input string name, input bit change_mid);
    int lat;
    @(negedge clk);
    bus.St = 1'b1; bus.Mplier = a; bus.Mcand = b;
    @(negedge clk);
    bus.St = 1'b0;
    lat = 1;
    while (bus.Done !== 1'b1 && lat < 20) begin
      if (change_mid && lat == 2) begin
        bus.Mplier = W'(1); bus.Mcand = W'(1);
      end
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(W + 1));
    chk({name, "_product"}, 64'(bus.Product), 64'(exp));
    $display("op %s: %0h * %0h -> %0h after %0d cycles", name, a, b, bus.Product, lat);
  endtask

  initial begin
    int done_idx[$];
    bus.St = 1'b0; bus.Mplier = '0; bus.Mcand = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy",    64'(bus.Busy),    64'(0));
    chk("reset_done",    64'(bus.Done),    64'(0));
    chk("reset_product", 64'(bus.Product), 64'(0));
    rst = 1'b0;

`ifdef MULT_SIGNED_EN
    run_op(4'hD, 4'h5, 8'hF1, "m3x5",   1'b0);
    run_op(4'h8, 4'h8, 8'h40, "m8xm8",  1'b0);
    run_op(4'h8, 4'h7, 8'hC8, "m8x7",   1'b0);
    run_op(4'h3, 4'h5, 8'h0F, "mid3x5", 1'b1);
`else
    run_op(4'd13, 4'd11, 8'd143, "13x11",  1'b0);
    run_op(4'd0,  4'd15, 8'd0,   "0x15",   1'b0);
    run_op(4'd15, 4'd15, 8'd225, "15x15",  1'b0);
    run_op(4'd9,  4'd5,  8'd45,  "mid9x5", 1'b1);
`endif
    // Product holds after completion.
    repeat (3) @(negedge clk);
    chk("hold_product", 64'(bus.Product), 64'(m_prod));

    // St held continuously: results every W+2 cycles.
    @(negedge clk);
    bus.St = 1'b1; bus.Mplier = W'(7); bus.Mcand = W'(1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.Done === 1'b1) begin
        done_idx.push_back(i);
        chk("held_product", 64'(bus.Product), 64'(7));
      end
    end
    bus.St = 1'b0;
    chk("held_count", 64'(done_idx.size()), 64'(3));
    if (done_idx.size() >= 3) begin
      chk("held_first",   64'(done_idx[0]),               64'(5));
      chk("held_period1", 64'(done_idx[1] - done_idx[0]), 64'(6));
      chk("held_period2", 64'(done_idx[2] - done_idx[1]), 64'(6));
    end
    $display("op held 7*1: done cycles %0d entries", done_idx.size());
    repeat (8) @(negedge clk);

    // Reset in the second RUN cycle aborts the operation.
    bus.St = 1'b1; bus.Mplier = W'(12); bus.Mcand = W'(12);
    @(negedge clk);
    bus.St = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy",    64'(bus.Busy),    64'(0));
    chk("abort_done",    64'(bus.Done),    64'(0));
    chk("abort_product", 64'(bus.Product), 64'(0));
    $display("op abort 12*12: reset applied mid-run");
    rst = 1'b0;
    run_op(W'(3), W'(3), 8'd9, "3x3", 1'b0);

    // Randomized stimulus; the per-cycle model compare checks everything.
    repeat (400) begin
      @(negedge clk);
      bus.St     = ($urandom_range(0, 3) != 0);
      bus.Mplier = W'($urandom);
      bus.Mcand  = W'($urandom);
      rst        = ($urandom_range(0, 60) == 0);
    end
    @(negedge clk);
    rst = 1'b0; bus.St = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
